reverse_bits_stream: RTL and testbench
======================================

# reverse_bits_stream

Streaming, parametrised successor to the combinational bit reverser. Accepts words over a valid/ready handshake. Applies a per-word reorder: pass-through, full bit reverse, bit reverse within each byte, or byte-order swap. Delivers each result one cycle later through a registered-ready skid stage, and keeps a saturating count of reordered words. It sits between any two streaming blocks needing endianness or bit-order conversion at full throughput.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of 8 and at least 8
- CNT_WIDTH, 16, width of the reordered-word counter
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_WIDTH  input word
- in_mode  input  2  reorder mode, sampled with in_data
- out_valid  output  1  output word present
- out_ready  input  1  downstream accepts output this cycle
- out_data  output  DATA_WIDTH  reordered word
- out_mode  output  2  mode the output word was processed with
- clear_count  input  1  synchronous clear of word_count
- word_count  output  CNT_WIDTH  number of delivered words with mode != 00, saturating

## Operation
- Modes:
  - 00: pass, out = in.
  - 01: full reverse, out[i] = in[DATA_WIDTH-1-i].
  - 10: bit reverse inside each byte; byte k bit j maps to byte k bit 7-j.
  - 11: byte swap; byte k maps to byte DATA_WIDTH/8-1-k.
- The transform is combinational on in_data/in_mode. The transformed word and its mode are captured on accept (in_valid && in_ready).
- Storage is a main register (out_*) plus one skid register, so there are two entries.
- Accept when out is empty, or when out is draining this cycle: the word goes to the main register.
- Accept while out_valid && !out_ready: the word goes to the skid register.
- On out handshake (out_valid && out_ready), the skid entry, if valid, moves to the main register in the same edge.
- in_ready = !skid_valid. It is a registered signal with no combinational path from out_ready.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- word_count increments on each out handshake with out_mode != 00. It holds at all-ones.
- clear_count forces word_count to 0. If a clear and an increment occur in the same cycle, the clear wins and word_count is 0.

## Timing
- Reset values: out_valid 0, out_data 0, out_mode 00, word_count 0, skid empty, in_ready 1.
- An async reset assertion mid-transfer discards both entries immediately. The first cycle after deassertion has in_ready = 1.
- Latency: a word accepted at edge N is presented with out_valid = 1 after edge N, when out was empty or draining.
- Throughput is one word per cycle while out_ready is held high.
- Backpressure:
  - After out_ready goes low with out full, one more word is accepted into skid.
  - in_ready falls at the next edge.
  - in_ready rises one cycle after the skid drains.
- out_data and out_mode are stable while out_valid && !out_ready.
- in_mode is a don't-care when in_valid = 0.

## Structure
- Package reverse_bits_pkg holds:
  - typedef enum logic [1:0] rev_mode_e with values REV_PASS, REV_FULL, REV_BYTE_BITS, REV_BYTE_SWAP;
  - a parametrised transform function.
- Sub-module rev_skid_buffer: a generic two-entry valid/ready stage, parametrised on payload width (DATA_WIDTH+2).
- The top level holds the transform, the skid instance and the counter.

## Test plan
- DATA_WIDTH=32, out_ready=1:
  - 0x00000001 mode 01 -> 0x80000000 one cycle later;
  - 0x12345678 mode 11 -> 0x78563412;
  - 0x12345678 mode 10 -> 0x482C6A1E;
  - 0xDEADBEEF mode 00 -> 0xDEADBEEF.
- Stream 8 words back-to-back with out_ready=1: in_ready stays 1, outputs appear in order at one per cycle, and word_count equals the count of non-00 modes.
- out_ready=0 while sending 4 words:
  - exactly 2 are accepted, and in_ready falls after the second;
  - out_data stays stable on the first word;
  - releasing out_ready delivers both in order, then in_ready returns to 1.
- Random valid/ready over 10k words in all modes: the scoreboard matches the reference transform with no loss or duplication.
- CNT_WIDTH=2, deliver 5 mode-01 words:
  - word_count reads 1, 2, 3, 3, 3;
  - clear_count coincident with a delivery gives 0.
- Assert reset with both entries full: out_valid is 0 and word_count is 0 immediately. After release, in_ready = 1 and the next word passes normally.

Source files
------------

// File: rtl/reverse_bits_pkg.sv
// Shared types and the word reorder transform
// for the reverse_bits_stream block.
package reverse_bits_pkg;

  typedef enum logic [1:0] {
    REV_PASS      = 2'b00,
    REV_FULL      = 2'b01,
    REV_BYTE_BITS = 2'b10,
    REV_BYTE_SWAP = 2'b11
  } rev_mode_e;

  localparam int MAX_DW = 256;

  // Bits at or above w are left zero; callers truncate to w.
  function automatic logic [MAX_DW-1:0] rev_transform(
    input logic [MAX_DW-1:0] d,
    input rev_mode_e         m,
    input int                w
  );
    logic [MAX_DW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      if (i < w) begin
        case (m)
          REV_PASS:      r[i] = d[i];
          REV_FULL:      r[i] = d[w-1-i];
          REV_BYTE_BITS: r[i] = d[(i/8)*8 + 7 - (i%8)];
          REV_BYTE_SWAP: r[i] = d[(w/8-1-(i/8))*8 + (i%8)];
          default:       r[i] = d[i];
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reverse_bits_stream_if.sv
// Valid/ready stream bundle: input side and
// output side of the reorder stage.
interface reverse_bits_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_mode;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/reverse_bits_stream_skid.sv
// Two-entry valid/ready stage: main output
// register plus one skid register.
module rev_skid_buffer #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept;
  logic             drain;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    accept = in_valid && !skid_valid_q;
    drain  = main_valid_q && out_ready;
    if (drain) begin
      main_valid_d = skid_valid_q;
      skid_valid_d = 1'b0;
      if (skid_valid_q) main_data_d = skid_data_q;
    end
    // accept implies skid empty, so drain left main free
    if (accept) begin
      if (!main_valid_q || drain) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
endmodule

// File: rtl/reverse_bits_stream.sv
// Streaming bit/byte reorder with a skid stage
// and a saturating count of reordered words.
module reverse_bits_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  reverse_bits_stream_if.slave io,
  input  logic                 clear_count,
  output logic [CNT_WIDTH-1:0] word_count
);
  import reverse_bits_pkg::*;

  localparam int PW = DATA_WIDTH + 2;

  logic [DATA_WIDTH-1:0] xf_data;
  logic [PW-1:0]         out_pl;
  logic                  out_fire;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    xf_data = DATA_WIDTH'(rev_transform(
      MAX_DW'(io.in_data),
      rev_mode_e'(io.in_mode),
      DATA_WIDTH));
  end

  rev_skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (io.in_valid),
    .in_ready  (io.in_ready),
    .in_data   ({io.in_mode, xf_data}),
    .out_valid (io.out_valid),
    .out_ready (io.out_ready),
    .out_data  (out_pl)
  );

  assign io.out_mode = out_pl[PW-1 -: 2];
  assign io.out_data = out_pl[DATA_WIDTH-1:0];
  assign out_fire    = io.out_valid && io.out_ready;
  assign word_count  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && io.out_mode != REV_PASS
        && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    if (clear_count) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: tb/tb_reverse_bits_stream.sv
// Randomized bench for reverse_bits_stream with a
// queue-based reference model and directed cases.
module tb_reverse_bits_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 1'b0;
  logic        clr2 = 1'b0;
  logic [15:0] wc;
  logic [1:0]  wc2;

  int total = 0;
  int bad = 0;
  int n_acc = 0;
  logic [33:0] exp_q[$];
  int unsigned mcnt = 0;

  reverse_bits_stream_if #(.DATA_WIDTH(32)) bus();
  reverse_bits_stream_if #(.DATA_WIDTH(32)) bus2();

  reverse_bits_stream #(
    .DATA_WIDTH(32), .CNT_WIDTH(16)
  ) u_dut (
    .clk(clk), .reset(reset), .io(bus),
    .clear_count(clr), .word_count(wc)
  );

  reverse_bits_stream #(
    .DATA_WIDTH(32), .CNT_WIDTH(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .io(bus2),
    .clear_count(clr2), .word_count(wc2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_xf(
    input logic [31:0] x, input logic [1:0] m
  );
    logic [31:0] r, b;
    case (m)
      2'd0: r = x;
      2'd1: r = {<<{x}};
      2'd2: begin b = {<<{x}}; r = {<<8{b}}; end
      default: r = {<<8{x}};
    endcase
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: queue holds exactly what the DUT stores.
  always @(negedge clk) begin
    logic can_acc, hs, nz;
    if (reset) begin
      exp_q.delete();
      mcnt = 0;
    end else begin
      chk("in_ready", 64'(bus.in_ready),
          64'(exp_q.size() < 2));
      chk("out_valid", 64'(bus.out_valid),
          64'(exp_q.size() != 0));
      chk("word_count", 64'(wc), 64'(mcnt));
      if (bus.out_valid && exp_q.size() != 0)
        chk("out_word",
            64'({bus.out_mode, bus.out_data}),
            64'(exp_q[0]));
      can_acc = bus.in_valid && exp_q.size() < 2;
      hs = bus.out_ready && exp_q.size() != 0;
      nz = hs && exp_q[0][33:32] != 2'd0;
      if (clr) mcnt = 0;
      else if (nz && mcnt != 32'hFFFF) mcnt++;
      if (hs) void'(exp_q.pop_front());
      if (can_acc) begin
        exp_q.push_back({bus.in_mode,
          ref_xf(bus.in_data, bus.in_mode)});
        n_acc++;
      end
    end
  end

  initial begin
    logic [31:0] vd[4];
    logic [1:0]  vm[4];
    logic [31:0] vx[4];
    logic [31:0] bw[4];
    int nzc, acc, cyc, start;
    logic rdy;
    int c2[5];

    vd = '{32'h00000001, 32'h12345678,
           32'h12345678, 32'hDEADBEEF};
    vm = '{2'd1, 2'd3, 2'd2, 2'd0};
    vx = '{32'h80000000, 32'h78563412,
           32'h482C6A1E, 32'hDEADBEEF};
    bus.in_valid = 0; bus.in_data = 0;
    bus.in_mode = 0; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.in_data = 0;
    bus2.in_mode = 0; bus2.out_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    chk("rst_out_mode", 64'(bus.out_mode), 0);
    chk("rst_count", 64'(wc), 0);
    reset = 0;
    step();

    // Pin the model, then the DUT, on literals.
    for (int i = 0; i < 4; i++) begin
      chk("model_pin", 64'(ref_xf(vd[i], vm[i])),
          64'(vx[i]));
      bus.in_valid = 1;
      bus.in_data = vd[i];
      bus.in_mode = vm[i];
      step();
      bus.in_valid = 0;
      chk("vec_valid", 64'(bus.out_valid), 1);
      chk("vec_data", 64'(bus.out_data), 64'(vx[i]));
      step();
    end
    chk("vec_count", 64'(wc), 3);

    clr = 1; step(); clr = 0;
    nzc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1;
      bus.in_data = $urandom;
      bus.in_mode = 2'($urandom_range(0, 3));
      if (bus.in_mode != 0) nzc++;
      chk("stream_ready", 64'(bus.in_ready), 1);
      step();
      chk("stream_valid", 64'(bus.out_valid), 1);
    end
    bus.in_valid = 0;
    step();
    chk("stream_count", 64'(wc), 64'(nzc));

    // Backpressure with four offered words.
    bw = '{32'hA1B2C3D4, 32'h0F0F0000,
           32'h11111111, 32'h22222222};
    bus.out_ready = 0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1;
      bus.in_data = bw[acc];
      bus.in_mode = (acc == 0) ? 2'd3 : 2'd1;
      rdy = bus.in_ready;
      step();
      if (rdy) acc++;
      chk("bp_hold", 64'(bus.out_data),
          64'h00000000D4C3B2A1);
    end
    bus.in_valid = 0;
    chk("bp_accepted", 64'(acc), 2);
    chk("bp_in_ready", 64'(bus.in_ready), 0);
    bus.out_ready = 1;
    step();
    chk("bp_second", 64'(bus.out_data),
        64'h000000000000F0F0);
    step();
    chk("bp_ready_back", 64'(bus.in_ready), 1);
    chk("bp_empty", 64'(bus.out_valid), 0);

    start = n_acc;
    cyc = 0;
    while (n_acc - start < 10000 && cyc < 60000) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_data = $urandom;
      bus.in_mode = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 63) == 0);
      step();
      cyc++;
    end
    chk("rand_budget",
        64'(n_acc - start >= 10000), 1);
    bus.in_valid = 0; bus.out_ready = 1; clr = 0;
    repeat (3) step();
    chk("drain_model", 64'(exp_q.size()), 0);
    chk("drain_valid", 64'(bus.out_valid), 0);

    // Saturation on the narrow counter.
    c2 = '{1, 2, 3, 3, 3};
    for (int k = 0; k < 5; k++) begin
      bus2.in_valid = 1;
      bus2.in_data = 32'(k);
      bus2.in_mode = 2'd1;
      step();
      bus2.in_valid = 0;
      step();
      chk("sat_count", 64'(wc2), 64'(c2[k]));
    end
    bus2.in_valid = 1;
    step();
    bus2.in_valid = 0; clr2 = 1;
    step();
    clr2 = 0;
    chk("clear_wins", 64'(wc2), 0);

    // Async reset with both entries full.
    bus.in_valid = 1; bus.in_data = 32'h5;
    bus.in_mode = 2'd1; bus.out_ready = 0;
    step(); step();
    bus.in_valid = 0;
    chk("full_ready", 64'(bus.in_ready), 0);
    #2 reset = 1;
    #1;
    chk("ar_valid", 64'(bus.out_valid), 0);
    chk("ar_count", 64'(wc), 0);
    step();
    reset = 0;
    bus.out_ready = 1;
    chk("ar_ready", 64'(bus.in_ready), 1);
    bus.in_valid = 1; bus.in_data = 32'h1;
    bus.in_mode = 2'd1;
    step();
    bus.in_valid = 0;
    chk("ar_next", 64'(bus.out_data),
        64'h0000000080000000);
    step();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
